fft_sdf_r2_stage: RTL and testbench

FFT_SDF_R2_STAGE -- requirements
Module: fft_sdf_r2_stage

---
 rtl/fft_sdf_r2_stage.sv | 152 +++++++++++++++
 tb/tb_fft_sdf_r2_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_sdf_r2_stage.sv
// fft_sdf_r2_stage: radix-2 single-delay-feedback FFT stage with external twiddle ROM.
// Define FFT_STAGE_SAT_EN to clamp outputs to OUT_W; otherwise outputs wrap.
module fft_sdf_r2_stage #(
    parameter int N         = 16,
    parameter int IN_W      = 8,
    parameter int OUT_W     = 8,
    parameter int TW_W      = 10,
    parameter int TW_STRIDE = 1,
    parameter int SHIFT     = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic signed [IN_W-1:0]            in_r,
    input  logic signed [IN_W-1:0]            in_i,
    output logic [$clog2(N*TW_STRIDE)-1:0]    tw_idx,
    input  logic signed [TW_W-1:0]            tw_r,
    input  logic signed [TW_W-1:0]            tw_i,
    output logic                              out_valid,
    output logic signed [OUT_W-1:0]           out_r,
    output logic signed [OUT_W-1:0]           out_i,
    output logic                              out_last
);
    localparam int H   = N / 2;
    localparam int CW  = $clog2(H);
    localparam int TIW = $clog2(N * TW_STRIDE);
    localparam int BW  = IN_W + 2;
    localparam int PW  = IN_W + TW_W;
    localparam int EW  = (OUT_W > BW ? OUT_W : BW) + 1;
`ifdef FFT_STAGE_SAT_EN
    localparam logic signed [EW-1:0] O_MAX = EW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [EW-1:0] O_MIN = ~O_MAX;
`endif

    typedef enum logic {FILL, PAIR} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d, dcnt_q, dcnt_d, k1_q, k1_d, rd_addr;
    logic                  drain_q, drain_d, v1_q, v1_d, pair1_q, pair1_d, last1_q, last1_d;
    logic                  out_valid_q, out_last_q, accept_pair, fill_wr;
    logic signed [BW-1:0]  bank_r_q [H];
    logic signed [BW-1:0]  bank_i_q [H];
    logic signed [BW-1:0]  a1_r_q, a1_i_q, a1_r_d, a1_i_d, sum_r, sum_i, dif_r, dif_i;
    logic signed [IN_W:0]  p1_r_q, p1_i_q, p1_r_d, p1_i_d;
    logic signed [PW-1:0]  pr_full, pi_full;
    logic signed [OUT_W-1:0] out_r_q, out_i_q, out_r_d, out_i_d;

    function automatic logic signed [OUT_W-1:0] fit(input logic signed [BW-1:0] v);
        logic signed [EW-1:0] e;
        e = EW'(v >>> SHIFT);
`ifdef FFT_STAGE_SAT_EN
        return e > O_MAX ? OUT_W'(O_MAX) : e < O_MIN ? OUT_W'(O_MIN) : OUT_W'(e);
`else
        return OUT_W'(e);
`endif
    endfunction

    assign accept_pair = in_valid && state_q == PAIR;
    assign fill_wr     = in_valid && state_q == FILL;
    assign tw_idx      = state_q == PAIR ? TIW'(cnt_q * TW_STRIDE) : '0;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_r       = out_r_q;
    assign out_i       = out_i_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        dcnt_d  = dcnt_q;
        if (in_valid) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(H - 1)) state_d = state_q == FILL ? PAIR : FILL;
        end
        if (drain_q) begin
            dcnt_d  = dcnt_q + CW'(1);
            drain_d = dcnt_q != CW'(H - 1);
        end
        // Drain can never overlap the previous one: a full FILL half-block separates them.
        if (accept_pair && cnt_q == CW'(H - 1)) begin
            drain_d = 1'b1;
            dcnt_d  = '0;
        end
        rd_addr = drain_q ? dcnt_q : cnt_q;
        pr_full = PW'(in_r) * PW'(tw_r) - PW'(in_i) * PW'(tw_i);
        pi_full = PW'(in_r) * PW'(tw_i) + PW'(in_i) * PW'(tw_r);
        v1_d    = accept_pair || drain_q;
        pair1_d = accept_pair;
        last1_d = drain_q && dcnt_q == CW'(H - 1);
        k1_d    = cnt_q;
        a1_r_d  = bank_r_q[rd_addr];
        a1_i_d  = bank_i_q[rd_addr];
        p1_r_d  = accept_pair ? (IN_W + 1)'(pr_full >>> (TW_W - 2)) : '0;
        p1_i_d  = accept_pair ? (IN_W + 1)'(pi_full >>> (TW_W - 2)) : '0;
        sum_r   = a1_r_q + BW'(p1_r_q);
        sum_i   = a1_i_q + BW'(p1_i_q);
        dif_r   = a1_r_q - BW'(p1_r_q);
        dif_i   = a1_i_q - BW'(p1_i_q);
        out_r_d = fit(sum_r);
        out_i_d = fit(sum_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            dcnt_q      <= '0;
            v1_q        <= 1'b0;
            pair1_q     <= 1'b0;
            last1_q     <= 1'b0;
            k1_q        <= '0;
            a1_r_q      <= '0;
            a1_i_q      <= '0;
            p1_r_q      <= '0;
            p1_i_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_r_q     <= '0;
            out_i_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            dcnt_q      <= dcnt_d;
            v1_q        <= v1_d;
            pair1_q     <= pair1_d;
            last1_q     <= last1_d;
            k1_q        <= k1_d;
            a1_r_q      <= a1_r_d;
            a1_i_q      <= a1_i_d;
            p1_r_q      <= p1_r_d;
            p1_i_q      <= p1_i_d;
            out_valid_q <= v1_q;
            out_last_q  <= last1_q;
            out_r_q     <= out_r_d;
            out_i_q     <= out_i_d;
        end
    end

    // Difference write-back and FILL writes never target the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (pair1_q) begin
            bank_r_q[k1_q] <= dif_r;
            bank_i_q[k1_q] <= dif_i;
        end
        if (fill_wr) begin
            bank_r_q[cnt_q] <= BW'(in_r);
            bank_i_q[cnt_q] <= BW'(in_i);
        end
    end
endmodule

// File: tb/tb_fft_sdf_r2_stage.sv
// tb_fft_sdf_r2_stage: scoreboard bench for fft_sdf_r2_stage (N=8, 8-bit samples, Q2.8 twiddles).
module tb_fft_sdf_r2_stage;
    localparam int N     = 8;
    localparam int H     = N / 2;
    localparam int SHIFT = 0;

    typedef struct {
        int r;
        int i;
        int last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_r = '0;
    logic signed [7:0] in_i = '0;
    logic [2:0]        tw_idx;
    logic signed [9:0] tw_r, tw_i;
    logic              out_valid, out_last;
    logic signed [7:0] out_r, out_i;

    int   n_chk = 0;
    int   n_fail = 0;
    int   mode = 0;
    int   run = 0;
    int   last_run = 0;
    int   bxr[N], bxi[N];
    int   rom_r[8] = '{256, 181, 0, -181, 0, 0, 0, 0};
    int   rom_i[8] = '{0, -181, -256, -181, 0, 0, 0, 0};
    exp_t q[$];
    exp_t cur;

    always #5 clk = ~clk;

    fft_sdf_r2_stage #(
        .N(N), .IN_W(8), .OUT_W(8), .TW_W(10), .TW_STRIDE(1), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
        .tw_idx(tw_idx), .tw_r(tw_r), .tw_i(tw_i),
        .out_valid(out_valid), .out_r(out_r), .out_i(out_i), .out_last(out_last)
    );

    function automatic int tw_val(input int k, input bit im);
        if (mode == 1) return im ? -256 : 0;
        if (mode == 2) return im ? rom_i[k] : rom_r[k];
        return im ? 0 : 256;
    endfunction

    assign tw_r = 10'(tw_val(int'(tw_idx), 1'b0));
    assign tw_i = 10'(tw_val(int'(tw_idx), 1'b1));

    function automatic int wrapn(input int v, input int b);
        return (v <<< (32 - b)) >>> (32 - b);
    endfunction

    function automatic int fit(input int v);
        int s;
        s = v >>> SHIFT;
`ifdef FFT_STAGE_SAT_EN
        return s > 127 ? 127 : s < -128 ? -128 : s;
`else
        return wrapn(s, 8);
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_block();
        int pr, pi, dr[H], di[H];
        for (int k = 0; k < H; k++) begin
            pr = wrapn((bxr[k+H] * tw_val(k, 0) - bxi[k+H] * tw_val(k, 1)) >>> 8, 9);
            pi = wrapn((bxr[k+H] * tw_val(k, 1) + bxi[k+H] * tw_val(k, 0)) >>> 8, 9);
            q.push_back('{fit(wrapn(bxr[k] + pr, 10)), fit(wrapn(bxi[k] + pi, 10)), 0});
            dr[k] = fit(wrapn(bxr[k] - pr, 10));
            di[k] = fit(wrapn(bxi[k] - pi, 10));
        end
        for (int k = 0; k < H; k++) q.push_back('{dr[k], di[k], int'(k == H - 1)});
    endtask

    task automatic drive_block(input bit gap, input int cnt, input bit do_push);
        if (do_push) push_block();
        for (int j = 0; j < cnt; j++) begin
            in_valid = 1'b1;
            in_r = 8'(bxr[j]);
            in_i = 8'(bxi[j]);
            check("tw_idx", int'(tw_idx), j >= H ? j - H : 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 200 && q.size() != 0; c++) @(posedge clk);
        check("queue_drained", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_block(input int sel);
        for (int j = 0; j < N; j++) begin
            bxr[j] = 0;
            bxi[j] = 0;
        end
        if (sel == 0) bxr[0] = 1;
        if (sel == 1) bxr[H] = 64;
        if (sel == 2) begin
            bxr[0] = 127;
            bxr[H] = 127;
        end
        if (sel == 3)
            for (int j = 0; j < N; j++) begin
                bxr[j] = int'($urandom_range(0, 255)) - 128;
                bxi[j] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    always @(negedge clk) begin
        run = out_valid ? run + 1 : 0;
        if (out_valid) begin
            if (q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                cur = q.pop_front();
                check("out_r", int'(out_r), cur.r);
                check("out_i", int'(out_i), cur.i);
                check("out_last", int'(out_last), cur.last);
                if (out_last) begin
                    check("drain_run", int'(run >= H), 1);
                    last_run = run;
                end
            end
        end
    end

    initial begin
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_r", int'(out_r), 0);
        check("rst_out_i", int'(out_i), 0);
        check("rst_tw_idx", int'(tw_idx), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mode = 0;
        set_block(0);
        drive_block(0, N, 1);
        wait_idle();
        mode = 1;
        set_block(1);
        drive_block(0, N, 1);
        wait_idle();
        mode = 0;
        set_block(2);
        drive_block(0, N, 1);
        wait_idle();
        mode = 2;
        for (int b = 0; b < 3; b++) begin
            set_block(3);
            drive_block(0, N, 1);
        end
        wait_idle();
        check("continuous_run", last_run, 3 * N);
        mode = 0;
        set_block(0);
        drive_block(1, N, 1);
        wait_idle();
        set_block(3);
        drive_block(0, 6, 0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_tw_idx", int'(tw_idx), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        set_block(0);
        drive_block(0, N, 1);
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
